pipelined_carry_adder: RTL and testbench

Parametrised, pipelined successor to the team's 8-bit ripple-carry adder: a WIDTH-bit adder split into SEG-bit ripple segments, one segment per pipeline stage, with the carry registered between stages. It accepts one operation per cycle under a valid/ready handshake and returns sum, carry-out and signed overflow after a fixed latency. It sits in the processor's execute stage as the wide integer adder.

---
 rtl/pca_pkg.sv | 19 +
 rtl/pca_segment.sv | 27 ++
 rtl/pipelined_carry_adder.sv | 119 +++++++++++
 tb/tb_pipelined_carry_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pca_pkg.sv
// Shared constants, stage-count helper and per-stage control struct for pipelined_carry_adder.
// PCA_SUB_EN enables the subtract-mode port on the top module.
package pca_pkg;

  localparam int PCA_WIDTH = 32;
  localparam int PCA_SEG   = 8;

  function automatic int pca_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // Control part of a stage register; operand and sum slices are sized per stage in the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic c_msb;
  } pca_ctrl_t;

endpackage

// File: rtl/pca_segment.sv
// Combinational SEG-bit ripple adder; also reports the carry into its MSB for overflow.
module pca_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    c_msb = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) c_msb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Skewed pipelined adder: one SEG-bit ripple segment per stage, carry registered between stages.
// Define PCA_SUB_EN to add the sub port (a + ~b + 1 when sub is high).
module pipelined_carry_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = PCA_WIDTH,
  parameter int SEG   = PCA_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef PCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             co,
  output logic             ov
);

  localparam int N = pca_stages(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_width
    $error("pipelined_carry_adder: WIDTH must be a multiple of SEG");
  end

  logic             stall;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

`ifdef PCA_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : ci;
`else
  assign b_in = b;
  assign c_in = ci;
`endif

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_stage
    localparam int PW = WIDTH - (gi + 1) * SEG;  // operand bits still pending after this stage
    localparam int DW = (gi + 1) * SEG;          // sum bits finished by this stage

    logic [SEG-1:0] seg_a, seg_b, seg_s;
    logic           seg_ci, seg_co, seg_cmsb, valid_src;
    logic [DW-1:0]  sum_next;
    logic [DW-1:0]  sum_reg;
    pca_ctrl_t      ctrl_reg;

    if (gi == 0) begin : g_first
      assign seg_a     = a[SEG-1:0];
      assign seg_b     = b_in[SEG-1:0];
      assign seg_ci    = c_in;
      assign valid_src = in_valid;
      assign sum_next  = seg_s;
    end else begin : g_next
      assign seg_a     = g_stage[gi-1].g_pend.a_pend[SEG-1:0];
      assign seg_b     = g_stage[gi-1].g_pend.b_pend[SEG-1:0];
      assign seg_ci    = g_stage[gi-1].ctrl_reg.carry;
      assign valid_src = g_stage[gi-1].ctrl_reg.valid;
      assign sum_next  = {seg_s, g_stage[gi-1].sum_reg};
    end

    pca_segment #(.SEG(SEG)) u_segment (
      .a     (seg_a),
      .b     (seg_b),
      .ci    (seg_ci),
      .s     (seg_s),
      .co    (seg_co),
      .c_msb (seg_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_reg  <= '0;
        ctrl_reg <= '0;
      end else if (!stall) begin
        sum_reg  <= sum_next;
        ctrl_reg <= '{valid: valid_src, carry: seg_co, c_msb: seg_cmsb};
      end
    end

    if (gi < N - 1) begin : g_pend
      logic [PW-1:0] a_pend, b_pend, a_pend_next, b_pend_next;

      if (gi == 0) begin : g_src_in
        assign a_pend_next = a[WIDTH-1:SEG];
        assign b_pend_next = b_in[WIDTH-1:SEG];
      end else begin : g_src_prev
        assign a_pend_next = g_stage[gi-1].g_pend.a_pend[PW+SEG-1:SEG];
        assign b_pend_next = g_stage[gi-1].g_pend.b_pend[PW+SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_pend <= '0;
          b_pend <= '0;
        end else if (!stall) begin
          a_pend <= a_pend_next;
          b_pend <= b_pend_next;
        end
      end
    end
  end

  assign out_valid = g_stage[N-1].ctrl_reg.valid;
  assign o         = g_stage[N-1].sum_reg;
  assign co        = g_stage[N-1].ctrl_reg.carry;
  assign ov        = g_stage[N-1].ctrl_reg.carry ^ g_stage[N-1].ctrl_reg.c_msb;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=32, SEG=8); subtract vectors run when PCA_SUB_EN is defined.
module tb_pipelined_carry_adder;

  localparam int W   = 32;
  localparam int NST = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, co, ov;
  logic [W-1:0] o;

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(W), .SEG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef PCA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .co        (co),
    .ov        (ov)
  );

  typedef struct {
    logic [W-1:0] o;
    logic         co;
    logic         ov;
    bit           lit;
    logic [W-1:0] lo;
    logic         lco;
    logic         lov;
    int           acc;
    int           st;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  exp_t         cmp_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           stalls = 0;
  bit           lit_en = 1'b0;
  logic [W-1:0] lit_o = '0;
  logic         lit_co = 1'b0;
  logic         lit_ov = 1'b0;
  logic [W-1:0] held_o;
  int           seen_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Result of one operation straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t         r;
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   s;
    bb   = sv ? ~bv : bv;
    cc   = sv ? 1'b1 : cv;
    s    = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, cc};
    r    = '{default: '0};
    r.o  = s[W-1:0];
    r.co = s[W];
    r.ov = (av[W-1] == bb[W-1]) && (s[W-1] != av[W-1]);
    return r;
  endfunction

  // Scoreboard bookkeeping on each edge: stall count, emits, accepts.
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (out_valid && !out_ready) stalls++;
      if (out_valid && out_ready && q.size() > 0) q.delete(0);
      if (in_valid && in_ready) begin
        mon_e     = model(a, b, ci, sub);
        mon_e.lit = lit_en;
        mon_e.lo  = lit_o;
        mon_e.lco = lit_co;
        mon_e.lov = lit_ov;
        mon_e.acc = cyc;
        mon_e.st  = stalls;
        q.push_back(mon_e);
        $display("accept a=%h b=%h ci=%0b sub=%0b -> expect o=%h co=%0b ov=%0b",
                 a, b, ci, sub, mon_e.o, mon_e.co, mon_e.ov);
      end
    end
  end

  always @(negedge rst_n) q.delete();

  // Per-cycle comparison against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          cmp_e = q[0];
          check("latency", cyc - cmp_e.acc - (stalls - cmp_e.st), NST - 1);
          check("o", o, cmp_e.o);
          check("co", co, cmp_e.co);
          check("ov", ov, cmp_e.ov);
          if (cmp_e.lit) begin
            check("lit_o", o, cmp_e.lo);
            check("lit_co", co, cmp_e.lco);
            check("lit_ov", ov, cmp_e.lov);
          end
          if (out_ready) $display("emit o=%h co=%0b ov=%0b", o, co, ov);
        end
      end else if (q.size() > 0) begin
        cmp_e = q[0];
        check("not_early", (cyc - cmp_e.acc - (stalls - cmp_e.st)) < NST - 1, 1'b1);
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input logic sv, input bit le, input logic [W-1:0] lo,
                      input logic lco, input logic lov);
    bit ok;
    a = av; b = bv; ci = cv; sub = sv;
    lit_en = le; lit_o = lo; lit_co = lco; lit_ov = lov;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
    end
    check("drain_queue", q.size(), 0);
    check("drain_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_o", o, 32'h0);
    check("rst_co", co, 1'b0);
    check("rst_ov", ov, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: latency and plain sum.
    send(32'h00000044, 32'h00000025, 1'b0, 1'b0, 1, 32'h00000069, 1'b0, 1'b0);
    drain();

    // Back-to-back directed vectors.
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1, 32'h00000000, 1'b1, 1'b0);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, 32'h80000000, 1'b0, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1, 32'h00000000, 1'b1, 1'b1);
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1, 32'h00000100, 1'b0, 1'b0);
    send(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1, 32'hACF13568, 1'b0, 1'b0);
    send(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    drain();

    // Four back-to-back ops, then a 3-cycle stall with a fifth op waiting.
    for (int i = 1; i <= 4; i++)
      send(32'h01010101 * i, 32'h000000F0 + i, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    a = 32'hCAFE0000; b = 32'h0000BABE; ci = 1'b0; lit_en = 1'b0;
    check("stall_out_valid", out_valid, 1'b1);
    held_o = o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold_o", o, held_o);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hCAFE0000, 32'h0000BABE, 1'b0, 1'b0, 1, 32'hCAFEBABE, 1'b0, 1'b0);
    drain();

    // Reset with three ops in flight: nothing may emerge afterwards.
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    send(32'h33333333, 32'h44444444, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    send(32'h55555555, 32'h66666666, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_o", o, 32'h0);
    check("midrst_co", co, 1'b0);
    check("midrst_ov", ov, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("midrst_no_emit", seen_valid, 0);
    @(posedge clk);
    #1;
    send(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1, 32'h00000003, 1'b0, 1'b0);
    drain();

`ifdef PCA_SUB_EN
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(32'h00000007, 32'h00000005, 1'b1, 1'b1, 1, 32'h00000002, 1'b1, 1'b0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
